packet_sender: RTL and testbench
================================

PACKET_SENDER -- requirements
Module: packet_sender

Interface
REQ-001 Parameter DATA_W, default 32: input word width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in words; SHALL be a power of 2, range 2..16.
REQ-003 Parameter HDR_EN, default 1: 1 = prefix each packet with header byte 8'hA5.
REQ-004 Parameter CHK_EN, default 1: 1 = append an XOR checksum byte to each packet.
REQ-005 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_data  input  DATA_W  word to send.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  FIFO can accept a word.
REQ-010 tx_data  output  8  byte to the UART transmitter.
REQ-011 tx_enable  output  1  tx_data is valid this cycle.
REQ-012 tx_ready  input  1  UART transmitter is idle and can accept a byte.
REQ-013 busy  output  1  a packet is in progress or the FIFO is non-empty.
REQ-014 words_sent  output  16  count of completed packets.

Function
REQ-015 A word SHALL be pushed into the FIFO on any cycle with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal NOT full, combinationally.
  - A pop in the same cycle SHALL NOT make a full FIFO accept a word.
REQ-017 When in_valid=1 and in_ready=0, the word SHALL be dropped and FIFO contents SHALL be unchanged.
REQ-018 The FIFO pointers SHALL wrap modulo DEPTH. Occupancy SHALL be tracked so that full and empty are distinct.
REQ-019 The FSM SHALL have these states: IDLE, LOAD, HDR, DATA, CHK, GAP.
REQ-020 IDLE: if the FIFO is non-empty, go to LOAD; otherwise stay in IDLE.
REQ-021 LOAD (one cycle): pop the head word into a shift register, clear the checksum, clear the byte counter.
  - Next state: HDR if HDR_EN=1, otherwise DATA.
REQ-022 Byte transfer: a byte SHALL be transferred on a cycle with tx_enable=1 and tx_ready=1.
  - tx_enable SHALL be asserted only in HDR, DATA and CHK.
  - tx_data SHALL be stable while tx_enable=1.
REQ-023 HDR: tx_data=8'hA5. On transfer, go to GAP, returning to DATA.
REQ-024 DATA: tx_data SHALL be the shift register's most significant byte, so bytes are sent MSB first.
  - On transfer: XOR the byte into the checksum, shift left by 8, increment the byte counter, go to GAP.
  - After GAP: if the counter is below DATA_W/8, return to DATA.
  - Otherwise go to CHK if CHK_EN=1, or finish the packet if CHK_EN=0.
REQ-025 CHK: tx_data = XOR of all DATA_W/8 data bytes; the header SHALL be excluded. On transfer, go to GAP, then finish.
REQ-026 GAP SHALL last exactly one cycle with tx_enable=0, so the UART has one cycle to deassert tx_ready.
REQ-027 Finishing a packet SHALL increment words_sent (wrapping from 16'hFFFF to 0) and go to IDLE.
  - A non-empty FIFO SHALL then cause LOAD on the next cycle.
REQ-028 While tx_ready=0 in HDR, DATA or CHK, the FSM SHALL hold its state with tx_enable=1 and tx_data unchanged.
REQ-029 busy SHALL be 1 when the state is not IDLE or the FIFO is non-empty.
REQ-030 Pushes SHALL be accepted in every FSM state.

Reset
REQ-031 Reset is sampled on the clock edge; reset=0 at an edge SHALL:
  - empty the FIFO;
  - set state=IDLE, tx_enable=0, tx_data=8'h00, words_sent=0, busy=0, in_ready=1.
REQ-032 Reset mid-packet SHALL abandon the packet immediately. No further bytes of that packet SHALL be sent.

Verification
REQ-033 DATA_W=32, HDR_EN=1, CHK_EN=1, tx_ready held 1, push 32'h11223344 -> tx_data sequence A5,11,22,33,44,44; each byte's tx_enable pulses are separated by one GAP cycle; then words_sent=1.
REQ-034 DEPTH=4, tx_ready held 0, push 5 words -> in_ready=0 after the 4th push; the 5th word is dropped; the bytes of exactly 4 packets follow once tx_ready=1.
REQ-035 tx_ready=0 for 10 cycles during the DATA byte 8'h22 -> tx_enable stays 1 with tx_data=22 throughout; after release the sequence continues with 33.
REQ-036 HDR_EN=0, CHK_EN=0, DATA_W=16, push 16'hBEEF -> exactly two bytes, BE then EF, with no header and no checksum.
REQ-037 reset=0 for one cycle after the 2nd data byte of a packet, with 2 words queued -> tx_enable=0, FIFO empty, in_ready=1, words_sent=0; no further bytes are sent.
REQ-038 Preload words_sent to 16'hFFFF via 65535 minimal-size packets (DATA_W=8, HDR_EN=0, CHK_EN=0), then send one more packet -> words_sent=0.

Source files
------------

// File: rtl/packet_sender.sv
// packet_sender: buffers input words in a small FIFO and streams each one to a
// byte-wide UART transmitter as a packet: optional 8'hA5 header, the word's
// bytes MSB first, then an optional XOR checksum. Every byte is followed by a
// one-cycle gap so the transmitter has time to drop tx_ready.
module packet_sender #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int HDR_EN = 1,
   parameter int CHK_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        tx_data,
   output logic              tx_enable,
   input  logic              tx_ready,
   output logic              busy,
   output logic [15:0]       words_sent
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [3:0]       NBYTES   = 4'(DATA_W / 8);
   localparam logic [7:0]       HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HDR  = 3'd2,
      ST_DATA = 3'd3,
      ST_CHK  = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   // Packet engine state
   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic [7:0]        r_chk;
   logic [7:0]        w_chk_nxt;
   logic [3:0]        r_bcnt;
   logic [3:0]        w_bcnt_nxt;
   logic              r_chk_sent;
   logic              w_chk_sent_nxt;
   logic              w_finish;
   logic [15:0]       r_words_sent;
   logic              r_tx_enable;
   logic              w_tx_enable_nxt;
   logic [7:0]        r_tx_data;
   logic [7:0]        w_tx_data_nxt;

   // The occupancy counter is one bit wider than the pointers so that a full
   // FIFO and an empty FIFO never look alike. A pop in the same cycle does not
   // relax full: in_ready depends on the registered count only.
   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign w_push   = in_valid & ~w_full;
   assign w_pop    = (r_state == ST_LOAD) & ~w_empty;

   assign in_ready   = ~w_full;
   assign busy       = (r_state != ST_IDLE) | ~w_empty;
   assign tx_enable  = r_tx_enable;
   assign tx_data    = r_tx_data;
   assign words_sent = r_words_sent;

   // FIFO data array: written on an accepted push, contents need no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Next-state and datapath updates for the packet FSM
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_chk_nxt      = r_chk;
      w_bcnt_nxt     = r_bcnt;
      w_chk_sent_nxt = r_chk_sent;
      w_finish       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            w_shift_nxt    = r_mem[r_rd_ptr];
            w_chk_nxt      = 8'h00;
            w_bcnt_nxt     = 4'd0;
            w_chk_sent_nxt = 1'b0;
            if (HDR_EN != 0) begin
               w_state_nxt = ST_HDR;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_HDR: begin
            if (tx_ready) begin
               w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_HDR;
            end
         end
         ST_DATA: begin
            if (tx_ready) begin
               w_chk_nxt   = r_chk ^ r_shift[DATA_W-1 -: 8];
               w_shift_nxt = r_shift << 4'd8;
               w_bcnt_nxt  = r_bcnt + 4'd1;
               w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_CHK: begin
            if (tx_ready) begin
               w_chk_sent_nxt = 1'b1;
               w_state_nxt    = ST_GAP;
            end else begin
               w_state_nxt = ST_CHK;
            end
         end
         ST_GAP: begin
            // The gap decides where the packet goes next: after the checksum it
            // ends, otherwise more data bytes, then checksum (if enabled).
            if (r_chk_sent) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_bcnt < NBYTES) begin
               w_state_nxt = ST_DATA;
            end else if (CHK_EN != 0) begin
               w_state_nxt = ST_CHK;
            end else begin
               w_finish    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte presented to the transmitter in the state being entered, so the
   // registered tx outputs line up with the state register
   always_comb begin
      w_tx_enable_nxt = 1'b0;
      w_tx_data_nxt   = 8'h00;
      case (w_state_nxt)
         ST_HDR: begin
            w_tx_enable_nxt = 1'b1;
            w_tx_data_nxt   = HDR_BYTE;
         end
         ST_DATA: begin
            w_tx_enable_nxt = 1'b1;
            w_tx_data_nxt   = w_shift_nxt[DATA_W-1 -: 8];
         end
         ST_CHK: begin
            w_tx_enable_nxt = 1'b1;
            w_tx_data_nxt   = w_chk_nxt;
         end
         default: begin
            w_tx_enable_nxt = 1'b0;
            w_tx_data_nxt   = 8'h00;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any packet at once
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_chk        <= 8'h00;
         r_bcnt       <= 4'd0;
         r_chk_sent   <= 1'b0;
         r_words_sent <= 16'h0000;
         r_tx_enable  <= 1'b0;
         r_tx_data    <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_chk       <= w_chk_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_chk_sent  <= w_chk_sent_nxt;
         r_tx_enable <= w_tx_enable_nxt;
         r_tx_data   <= w_tx_data_nxt;
         if (w_finish) begin
            r_words_sent <= r_words_sent + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_packet_sender.sv
// tb_packet_sender: scoreboard bench for packet_sender. Three instances cover
// the full-featured 32-bit packet, the bare 16-bit packet and the 8-bit
// packet used for the words_sent wrap.
module tb_packet_sender;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [31:0] in_data_a;
   logic        in_valid_a, in_ready_a, tx_enable_a, tx_ready_a, busy_a;
   logic [7:0]  tx_data_a;
   logic [15:0] words_sent_a;

   logic [15:0] in_data_b;
   logic        in_valid_b, in_ready_b, tx_enable_b, tx_ready_b, busy_b;
   logic [7:0]  tx_data_b;
   logic [15:0] words_sent_b;

   logic [7:0]  in_data_c;
   logic        in_valid_c, in_ready_c, tx_enable_c, tx_ready_c, busy_c;
   logic [7:0]  tx_data_c;
   logic [15:0] words_sent_c;

   packet_sender #(.DATA_W(32), .DEPTH(4), .HDR_EN(1), .CHK_EN(1)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .tx_data(tx_data_a), .tx_enable(tx_enable_a),
      .tx_ready(tx_ready_a), .busy(busy_a), .words_sent(words_sent_a));

   packet_sender #(.DATA_W(16), .DEPTH(4), .HDR_EN(0), .CHK_EN(0)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .tx_data(tx_data_b), .tx_enable(tx_enable_b),
      .tx_ready(tx_ready_b), .busy(busy_b), .words_sent(words_sent_b));

   packet_sender #(.DATA_W(8), .DEPTH(2), .HDR_EN(0), .CHK_EN(0)) dut_c (
      .clk(clk), .reset(reset), .in_data(in_data_c), .in_valid(in_valid_c),
      .in_ready(in_ready_c), .tx_data(tx_data_c), .tx_enable(tx_enable_c),
      .tx_ready(tx_ready_c), .busy(busy_c), .words_sent(words_sent_c));

   int n_cmp = 0;
   int n_err = 0;
   int exp_ws_a = 0;
   logic [7:0] q_exp_a[$];
   logic [7:0] q_obs_a[$];
   logic [7:0] q_exp_b[$];
   logic [7:0] q_obs_b[$];
   logic [7:0] q_exp_c[$];
   logic [7:0] q_obs_c[$];

   // Record every byte handshake, sampled mid-cycle before the transferring edge
   always @(negedge clk) begin
      if (tx_enable_a && tx_ready_a) q_obs_a.push_back(tx_data_a);
      if (tx_enable_b && tx_ready_b) q_obs_b.push_back(tx_data_b);
      if (tx_enable_c && tx_ready_c) q_obs_c.push_back(tx_data_c);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] w);
      in_data_a  = w;
      in_valid_a = 1'b1;
      step();
      in_valid_a = 1'b0;
   endtask

   // Model of one full packet: header, bytes MSB first, XOR of data bytes
   task automatic expect_a(input logic [31:0] w);
      logic [7:0] x;
      x = 8'h00;
      q_exp_a.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) begin
         q_exp_a.push_back(w[i*8 +: 8]);
         x = x ^ w[i*8 +: 8];
      end
      q_exp_a.push_back(x);
   endtask

   task automatic wait_idle_a(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy_a) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      in_data_a = 32'h0; in_valid_a = 1'b0; tx_ready_a = 1'b1;
      in_data_b = 16'h0; in_valid_b = 1'b0; tx_ready_b = 1'b1;
      in_data_c = 8'h0;  in_valid_c = 1'b0; tx_ready_c = 1'b1;
      reset = 1'b0;
      step();
      step();
      n_cmp++; if (tx_enable_a !== 1'b0) begin n_err++; $display("FAIL reset_tx_enable: got %b expected 0", tx_enable_a); end
      n_cmp++; if (tx_data_a !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data_a); end
      n_cmp++; if (words_sent_a !== 16'h0000) begin n_err++; $display("FAIL reset_words_sent: got %h expected 0000", words_sent_a); end
      n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a); end
      n_cmp++; if (in_ready_b !== 1'b1 || in_ready_c !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_bc: got %b%b expected 11", in_ready_b, in_ready_c); end
      reset = 1'b1;
      step();
   endtask

   // Single packet with tx_ready held high: byte order and one-cycle gaps
   task automatic test_basic();
      logic [7:0] e, o;
      int n_en, run;
      bit seen, ok;
      n_en = 0; run = 0; seen = 1'b0; ok = 1'b0;
      tx_ready_a = 1'b1;
      expect_a(32'h11223344);
      push_a(32'h11223344);
      for (int i = 0; i < 80; i++) begin
         if (tx_enable_a) begin
            if (seen) begin
               n_cmp++;
               if (run != 1) begin n_err++; $display("FAIL basic_gap: got %0d idle cycles expected 1", run); end
            end
            seen = 1'b1; run = 0; n_en++;
         end else begin
            run++;
         end
         if (!busy_a) begin ok = 1'b1; break; end
         step();
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: got busy expected idle"); end
      n_cmp++; if (n_en != 6) begin n_err++; $display("FAIL basic_pulses: got %0d expected 6", n_en); end
      while (q_exp_a.size() > 0) begin
         e = q_exp_a.pop_front();
         n_cmp++;
         if (q_obs_a.size() == 0) begin n_err++; $display("FAIL basic_byte: got none expected %h", e); end
         else begin o = q_obs_a.pop_front(); if (o !== e) begin n_err++; $display("FAIL basic_byte: got %h expected %h", o, e); end end
      end
      n_cmp++; if (q_obs_a.size() != 0) begin n_err++; $display("FAIL basic_extra: got %0d extra bytes expected 0", q_obs_a.size()); q_obs_a.delete(); end
      exp_ws_a++;
      n_cmp++; if (words_sent_a !== 16'(exp_ws_a)) begin n_err++; $display("FAIL basic_words_sent: got %0d expected %0d", words_sent_a, exp_ws_a); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e, o;
      bit ok;
      tx_ready_a = 1'b1;
      expect_a(32'h01020304);
      expect_a(32'hDEADBEEF);
      push_a(32'h01020304);
      push_a(32'hDEADBEEF);
      wait_idle_a(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got busy expected idle"); end
      while (q_exp_a.size() > 0) begin
         e = q_exp_a.pop_front();
         n_cmp++;
         if (q_obs_a.size() == 0) begin n_err++; $display("FAIL b2b_byte: got none expected %h", e); end
         else begin o = q_obs_a.pop_front(); if (o !== e) begin n_err++; $display("FAIL b2b_byte: got %h expected %h", o, e); end end
      end
      n_cmp++; if (q_obs_a.size() != 0) begin n_err++; $display("FAIL b2b_extra: got %0d extra bytes expected 0", q_obs_a.size()); q_obs_a.delete(); end
      exp_ws_a += 2;
      n_cmp++; if (words_sent_a !== 16'(exp_ws_a)) begin n_err++; $display("FAIL b2b_words_sent: got %0d expected %0d", words_sent_a, exp_ws_a); end
   endtask

   // Stall the transmitter while data byte 22 is on the bus
   task automatic test_hold();
      logic [7:0] e, o;
      bit found, ok;
      found = 1'b0;
      tx_ready_a = 1'b1;
      expect_a(32'h11223344);
      push_a(32'h11223344);
      for (int i = 0; i < 40; i++) begin
         if (tx_enable_a && tx_data_a == 8'h22) begin
            tx_ready_a = 1'b0;
            found = 1'b1;
            break;
         end
         step();
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL hold_reach: got no byte 22 expected byte 22"); end
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if (tx_enable_a !== 1'b1) begin n_err++; $display("FAIL hold_enable: got %b expected 1", tx_enable_a); end
         n_cmp++; if (tx_data_a !== 8'h22) begin n_err++; $display("FAIL hold_data: got %h expected 22", tx_data_a); end
      end
      tx_ready_a = 1'b1;
      wait_idle_a(100, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_timeout: got busy expected idle"); end
      while (q_exp_a.size() > 0) begin
         e = q_exp_a.pop_front();
         n_cmp++;
         if (q_obs_a.size() == 0) begin n_err++; $display("FAIL hold_byte: got none expected %h", e); end
         else begin o = q_obs_a.pop_front(); if (o !== e) begin n_err++; $display("FAIL hold_byte: got %h expected %h", o, e); end end
      end
      n_cmp++; if (q_obs_a.size() != 0) begin n_err++; $display("FAIL hold_extra: got %0d extra bytes expected 0", q_obs_a.size()); q_obs_a.delete(); end
      exp_ws_a++;
   endtask

   // Engine parked on a blocker packet's header, then five pushes into a
   // four-deep FIFO: four are kept, the fifth is dropped
   task automatic test_fifo_full();
      logic [7:0] e, o;
      logic [31:0] w;
      bit ok, exp_rdy;
      ok = 1'b0;
      tx_ready_a = 1'b0;
      expect_a(32'hCAFE0001);
      push_a(32'hCAFE0001);
      for (int i = 0; i < 10; i++) begin
         if (tx_enable_a) begin ok = 1'b1; break; end
         step();
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL full_park: got no header expected header"); end
      for (int k = 0; k < 5; k++) begin
         w = {8'(k), 8'h5A, 8'(k + 16), 8'hC3};
         exp_rdy = (k < 4);
         n_cmp++; if (in_ready_a !== exp_rdy) begin n_err++; $display("FAIL full_in_ready%0d: got %b expected %b", k, in_ready_a, exp_rdy); end
         if (exp_rdy) expect_a(w);
         push_a(w);
      end
      n_cmp++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL full_after: got %b expected 0", in_ready_a); end
      tx_ready_a = 1'b1;
      wait_idle_a(400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL full_timeout: got busy expected idle"); end
      while (q_exp_a.size() > 0) begin
         e = q_exp_a.pop_front();
         n_cmp++;
         if (q_obs_a.size() == 0) begin n_err++; $display("FAIL full_byte: got none expected %h", e); end
         else begin o = q_obs_a.pop_front(); if (o !== e) begin n_err++; $display("FAIL full_byte: got %h expected %h", o, e); end end
      end
      n_cmp++; if (q_obs_a.size() != 0) begin n_err++; $display("FAIL full_extra: got %0d extra bytes expected 0", q_obs_a.size()); q_obs_a.delete(); end
      exp_ws_a += 5;
      n_cmp++; if (words_sent_a !== 16'(exp_ws_a)) begin n_err++; $display("FAIL full_words_sent: got %0d expected %0d", words_sent_a, exp_ws_a); end
   endtask

   task automatic test_no_hdr_chk();
      logic [7:0] e, o;
      bit ok;
      ok = 1'b0;
      tx_ready_b = 1'b1;
      q_exp_b.push_back(8'hBE);
      q_exp_b.push_back(8'hEF);
      in_data_b = 16'hBEEF; in_valid_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!busy_b) begin ok = 1'b1; break; end
         step();
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bare_timeout: got busy expected idle"); end
      while (q_exp_b.size() > 0) begin
         e = q_exp_b.pop_front();
         n_cmp++;
         if (q_obs_b.size() == 0) begin n_err++; $display("FAIL bare_byte: got none expected %h", e); end
         else begin o = q_obs_b.pop_front(); if (o !== e) begin n_err++; $display("FAIL bare_byte: got %h expected %h", o, e); end end
      end
      n_cmp++; if (q_obs_b.size() != 0) begin n_err++; $display("FAIL bare_extra: got %0d extra bytes expected 0", q_obs_b.size()); q_obs_b.delete(); end
      n_cmp++; if (words_sent_b !== 16'd1) begin n_err++; $display("FAIL bare_words_sent: got %0d expected 1", words_sent_b); end
   endtask

   // Reset pulse right after the second data byte, two words still queued
   task automatic test_reset_mid();
      bit ok;
      ok = 1'b0;
      tx_ready_a = 1'b1;
      push_a(32'hAABBCCDD);
      push_a(32'h12345678);
      push_a(32'h9ABCDEF0);
      for (int i = 0; i < 60; i++) begin
         if (q_obs_a.size() >= 3) begin ok = 1'b1; break; end
         step();
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_reach: got %0d bytes expected 3", q_obs_a.size()); end
      reset = 1'b0;
      step();
      reset = 1'b1;
      exp_ws_a = 0;
      n_cmp++; if (tx_enable_a !== 1'b0) begin n_err++; $display("FAIL rmid_tx_enable: got %b expected 0", tx_enable_a); end
      n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rmid_fifo_empty: got busy %b expected 0", busy_a); end
      n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready_a); end
      n_cmp++; if (words_sent_a !== 16'h0000) begin n_err++; $display("FAIL rmid_words_sent: got %0d expected 0", words_sent_a); end
      for (int i = 0; i < 40; i++) step();
      n_cmp++; if (q_obs_a.size() != 3) begin n_err++; $display("FAIL rmid_no_more: got %0d bytes expected 3", q_obs_a.size()); end
      n_cmp++; if (q_obs_a.size() >= 3 && (q_obs_a[0] !== 8'hA5 || q_obs_a[1] !== 8'hAA || q_obs_a[2] !== 8'hBB)) begin
         n_err++; $display("FAIL rmid_bytes: got %h %h %h expected a5 aa bb", q_obs_a[0], q_obs_a[1], q_obs_a[2]);
      end
      q_obs_a.delete();
   endtask

   // words_sent wrap: one real packet, counter parked at FFFF, one more packet
   task automatic test_wrap();
      logic [7:0] e, o;
      bit ok;
      tx_ready_c = 1'b1;
      for (int p = 0; p < 2; p++) begin
         ok = 1'b0;
         e = (p == 0) ? 8'h5A : 8'hC3;
         q_exp_c.push_back(e);
         in_data_c = e; in_valid_c = 1'b1;
         step();
         in_valid_c = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (!busy_c) begin ok = 1'b1; break; end
            step();
         end
         n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout%0d: got busy expected idle", p); end
         while (q_exp_c.size() > 0) begin
            e = q_exp_c.pop_front();
            n_cmp++;
            if (q_obs_c.size() == 0) begin n_err++; $display("FAIL wrap_byte: got none expected %h", e); end
            else begin o = q_obs_c.pop_front(); if (o !== e) begin n_err++; $display("FAIL wrap_byte: got %h expected %h", o, e); end end
         end
         if (p == 0) begin
            n_cmp++; if (words_sent_c !== 16'h0001) begin n_err++; $display("FAIL wrap_first: got %h expected 0001", words_sent_c); end
            force dut_c.r_words_sent = 16'hFFFF;
            step();
            release dut_c.r_words_sent;
            step();
         end else begin
            n_cmp++; if (words_sent_c !== 16'h0000) begin n_err++; $display("FAIL wrap_words_sent: got %h expected 0000", words_sent_c); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hold();
      test_fifo_full();
      test_no_hdr_chk();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
